// File: rtl/change_dispense_scheduler.sv
// Coin-change payout sequencer: dispenses dimes first, falls back to nickels,
// tracks hopper inventory and jam status, and reports any unpaid remainder.
module change_dispense_scheduler #(
  parameter int AMT_W   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             disp_10c,
  output logic             disp_5c,
  input  logic             hop_ack,
  input  logic             refill_10c,
  input  logic             refill_5c,
  input  logic [CNT_W-1:0] refill_count,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] short_amount,
  output logic [CNT_W-1:0] inv_10c,
  output logic [CNT_W-1:0] inv_5c,
  output logic             jam_10c,
  output logic             jam_5c,
  output logic             busy
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_DISP10 = 3'd2,
    S_DISP5  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [AMT_W-1:0] r_remaining, w_remaining_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [CNT_W-1:0] r_inv_10c, r_inv_5c;
  logic             r_jam_10c, r_jam_5c;
  logic             w_dec10, w_dec5, w_jam10_set, w_jam5_set;

  // Refill and coin drop in the same cycle combine; result saturates at all-ones.
  function automatic logic [CNT_W-1:0] inv_update(
    input logic [CNT_W-1:0] inv,
    input logic             add,
    input logic [CNT_W-1:0] cnt,
    input logic             dec
  );
    logic [CNT_W:0] sum;
    sum = {1'b0, inv}
        + (add ? {1'b0, cnt} : {(CNT_W+1){1'b0}})
        - (dec ? {{CNT_W{1'b0}}, 1'b1} : {(CNT_W+1){1'b0}});
    if (sum[CNT_W]) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  // Next-state, remaining-amount and timer decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_timer_nxt     = {TMR_W{1'b0}};
    w_dec10         = 1'b0;
    w_dec5          = 1'b0;
    w_jam10_set     = 1'b0;
    w_jam5_set      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_remaining_nxt = req_amount;
          w_state_nxt     = S_SELECT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SELECT: begin
        if ((r_remaining >= AMT_W'(2)) && (r_inv_10c != {CNT_W{1'b0}}) && !r_jam_10c) begin
          w_state_nxt = S_DISP10;
        end else if ((r_remaining != {AMT_W{1'b0}}) && (r_inv_5c != {CNT_W{1'b0}}) && !r_jam_5c) begin
          w_state_nxt = S_DISP5;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DISP10: begin
        if (hop_ack) begin
          w_dec10         = 1'b1;
          w_remaining_nxt = r_remaining - AMT_W'(2);
          w_state_nxt     = S_SELECT;
        end else if (r_timer == TMR_LAST) begin
          w_jam10_set = 1'b1;
          w_state_nxt = S_SELECT;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      S_DISP5: begin
        if (hop_ack) begin
          w_dec5          = 1'b1;
          w_remaining_nxt = r_remaining - AMT_W'(1);
          w_state_nxt     = S_SELECT;
        end else if (r_timer == TMR_LAST) begin
          w_jam5_set  = 1'b1;
          w_state_nxt = S_SELECT;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters, inventory and jam flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= {AMT_W{1'b0}};
      r_timer     <= {TMR_W{1'b0}};
      r_inv_10c   <= {CNT_W{1'b0}};
      r_inv_5c    <= {CNT_W{1'b0}};
      r_jam_10c   <= 1'b0;
      r_jam_5c    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_timer     <= w_timer_nxt;
      r_inv_10c   <= inv_update(r_inv_10c, refill_10c, refill_count, w_dec10);
      r_inv_5c    <= inv_update(r_inv_5c, refill_5c, refill_count, w_dec5);
      // A timeout in the same cycle as a refill still marks the hopper jammed.
      if (w_jam10_set) begin
        r_jam_10c <= 1'b1;
      end else if (refill_10c) begin
        r_jam_10c <= 1'b0;
      end else begin
        r_jam_10c <= r_jam_10c;
      end
      if (w_jam5_set) begin
        r_jam_5c <= 1'b1;
      end else if (refill_5c) begin
        r_jam_5c <= 1'b0;
      end else begin
        r_jam_5c <= r_jam_5c;
      end
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign disp_10c     = (r_state == S_DISP10);
  assign disp_5c      = (r_state == S_DISP5);
  assign done         = (r_state == S_DONE);
  assign short        = done && (r_remaining != {AMT_W{1'b0}});
  assign short_amount = done ? r_remaining : {AMT_W{1'b0}};
  assign inv_10c      = r_inv_10c;
  assign inv_5c       = r_inv_5c;
  assign jam_10c      = r_jam_10c;
  assign jam_5c       = r_jam_5c;

endmodule

// File: tb/tb_change_dispense_scheduler.sv
// Scoreboard bench: directed payouts push expected coin/done/status records,
// and an independent monitor pops and compares them as the DUT presents events.
module tb_change_dispense_scheduler;
  localparam int AMT_W = 4;
  localparam int CNT_W = 8;
  localparam int TIMEOUT = 255;
  localparam int K_C10 = 0, K_C5 = 1, K_DONE = 2, K_STAT = 3, K_TO = 4;

  typedef struct {
    int kind;
    int len;
    int shrt;
    int samt;
    int i10;
    int i5;
    int j10;
    int j5;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic hop_ack = 1'b0, refill_10c = 1'b0, refill_5c = 1'b0;
  logic [CNT_W-1:0] refill_count = '0;
  logic req_ready, disp_10c, disp_5c, done, short, jam_10c, jam_5c, busy;
  logic [AMT_W-1:0] short_amount;
  logic [CNT_W-1:0] inv_10c, inv_5c;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  change_dispense_scheduler #(.AMT_W(AMT_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .disp_10c(disp_10c), .disp_5c(disp_5c), .hop_ack(hop_ack),
    .refill_10c(refill_10c), .refill_5c(refill_5c), .refill_count(refill_count),
    .done(done), .short(short), .short_amount(short_amount), .inv_10c(inv_10c),
    .inv_5c(inv_5c), .jam_10c(jam_10c), .jam_5c(jam_5c), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(int kind, int len, int shrt, int samt, int i10, int i5, int j10, int j5);
    exp_t e;
    e.kind = kind; e.len = len; e.shrt = shrt; e.samt = samt;
    e.i10 = i10; e.i5 = i5; e.j10 = j10; e.j5 = j5;
    return e;
  endfunction

  task automatic push_coin(int kind, int len);
    exp_q.push_back(mk(kind, len, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic push_done(int shrt, int samt, int i10, int i5);
    exp_q.push_back(mk(K_DONE, 0, shrt, samt, i10, i5, 0, 0));
  endtask

  task automatic push_stat(int i10, int i5, int j10, int j5);
    exp_q.push_back(mk(K_STAT, 0, 0, 0, i10, i5, j10, j5));
  endtask

  // ---------------- monitor ----------------
  task automatic mon_event(int kind_act, int len_act);
    exp_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind %0d len %0d, required no event", kind_act, len_act);
      return;
    end
    e = exp_q.pop_front();
    if (kind_act == K_DONE) begin
      if (e.kind != K_DONE || short !== e.shrt[0] || short_amount !== AMT_W'(e.samt) ||
          inv_10c !== CNT_W'(e.i10) || inv_5c !== CNT_W'(e.i5)) begin
        n_err++;
        $display("FAIL done: got kind %0d short %0b amt %0d inv %0d/%0d, required kind %0d short %0d amt %0d inv %0d/%0d",
                 kind_act, short, short_amount, inv_10c, inv_5c, e.kind, e.shrt, e.samt, e.i10, e.i5);
      end
    end else begin
      if (e.kind != kind_act || (e.len != 0 && e.len != len_act)) begin
        n_err++;
        $display("FAIL coin: got kind %0d len %0d, required kind %0d len %0d",
                 kind_act, len_act, e.kind, e.len);
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    bit prev10, prev5;
    int run10, run5;
    prev10 = 1'b0; prev5 = 1'b0; run10 = 0; run5 = 0;
    forever begin
      @(negedge clk);
      if (prev10 && !disp_10c) begin mon_event(K_C10, run10); run10 = 0; end
      if (prev5 && !disp_5c) begin mon_event(K_C5, run5); run5 = 0; end
      if (disp_10c) run10++;
      if (disp_5c) run5++;
      prev10 = disp_10c;
      prev5 = disp_5c;
      if (done) mon_event(K_DONE, 0);
      if (exp_q.size() != 0 && exp_q[0].kind == K_STAT) begin
        e = exp_q.pop_front();
        n_vec++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || disp_10c !== 1'b0 || disp_5c !== 1'b0 ||
            done !== 1'b0 || short !== 1'b0 || short_amount !== '0 ||
            inv_10c !== CNT_W'(e.i10) || inv_5c !== CNT_W'(e.i5) ||
            jam_10c !== e.j10[0] || jam_5c !== e.j5[0]) begin
          n_err++;
          $display("FAIL status: got rdy %0b busy %0b d10 %0b d5 %0b done %0b short %0b/%0d inv %0d/%0d jam %0b/%0b, required rdy 1 busy 0 idle outputs inv %0d/%0d jam %0d/%0d",
                   req_ready, busy, disp_10c, disp_5c, done, short, short_amount, inv_10c, inv_5c,
                   jam_10c, jam_5c, e.i10, e.i5, e.j10, e.j5);
        end
      end
      if (exp_q.size() != 0 && exp_q[0].kind == K_TO) begin
        e = exp_q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL timeout: got no DUT event within bound %0d, required event", e.len);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flag_timeout(int bound);
    exp_q.delete();
    exp_q.push_back(mk(K_TO, bound, 0, 0, 0, 0, 0, 0));
    cyc(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic refill(bit r10, bit r5, int cnt);
    refill_10c = r10; refill_5c = r5; refill_count = CNT_W'(cnt);
    cyc(1);
    refill_10c = 1'b0; refill_5c = 1'b0; refill_count = '0;
  endtask

  task automatic request(int amt);
    req_valid = 1'b1; req_amount = AMT_W'(amt);
    cyc(1);
    req_valid = 1'b0; req_amount = '0;
  endtask

  task automatic wait_disp();
    int t = 0;
    while (!(disp_10c || disp_5c) && t < 400) begin cyc(1); t++; end
    if (t >= 400) flag_timeout(400);
  endtask

  task automatic wait_fall();
    int t = 0;
    while ((disp_10c || disp_5c) && t < 400) begin cyc(1); t++; end
    if (t >= 400) flag_timeout(400);
  endtask

  task automatic ack_coin(int lat, bit r10, bit r5, int cnt);
    wait_disp();
    cyc(lat);
    hop_ack = 1'b1;
    refill_10c = r10; refill_5c = r5; refill_count = CNT_W'(cnt);
    cyc(1);
    hop_ack = 1'b0;
    refill_10c = 1'b0; refill_5c = 1'b0; refill_count = '0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 600) begin cyc(1); t++; end
    if (t >= 600) flag_timeout(600);
    cyc(1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion, required summary before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // Reset state
    cyc(3);
    push_stat(0, 0, 0, 0);
    cyc(2);
    rst = 1'b0;
    wait_drain();

    // 15c with inventory 5/5: one dime (ack on first cycle), then one nickel
    refill(1'b1, 1'b1, 5);
    push_coin(K_C10, 1); push_coin(K_C5, 3); push_done(0, 0, 4, 4);
    request(3);
    ack_coin(0, 1'b0, 1'b0, 0);
    ack_coin(2, 1'b0, 1'b0, 0);
    wait_drain();

    // Zero amount: straight to done
    push_done(0, 0, 4, 4);
    request(0);
    wait_drain();

    // No dimes: 20c from four nickels
    do_reset();
    refill(1'b0, 1'b1, 9);
    for (int i = 0; i < 4; i++) push_coin(K_C5, 0);
    push_done(0, 0, 0, 5);
    request(4);
    for (int i = 0; i < 4; i++) ack_coin(i, 1'b0, 1'b0, 0);
    wait_drain();

    // Shortfall: one nickel for 15c
    do_reset();
    refill(1'b0, 1'b1, 1);
    push_coin(K_C5, 0); push_done(1, 2, 0, 0);
    request(3);
    ack_coin(1, 1'b0, 1'b0, 0);
    wait_drain();

    // Dime jam: disp held TIMEOUT cycles, then two nickels cover 10c
    do_reset();
    refill(1'b1, 1'b1, 3);
    push_coin(K_C10, TIMEOUT); push_coin(K_C5, 0); push_coin(K_C5, 0);
    push_done(0, 0, 3, 1);
    request(2);
    wait_disp();
    wait_fall();
    ack_coin(0, 1'b0, 1'b0, 0);
    ack_coin(1, 1'b0, 1'b0, 0);
    wait_drain();
    push_stat(3, 1, 1, 0);
    wait_drain();
    refill(1'b1, 1'b0, 0);
    push_stat(3, 1, 0, 0);
    wait_drain();

    // Refill coincident with ack: 254+10-1 saturates, 5+2-1 = 6
    do_reset();
    refill(1'b1, 1'b0, 254);
    refill(1'b0, 1'b1, 5);
    push_coin(K_C10, 0); push_coin(K_C5, 0); push_done(0, 0, 255, 6);
    request(3);
    ack_coin(1, 1'b1, 1'b0, 10);
    ack_coin(0, 1'b0, 1'b1, 2);
    wait_drain();

    // 250+10-1 = 259 saturates to 255
    do_reset();
    refill(1'b1, 1'b0, 250);
    push_coin(K_C10, 0); push_done(0, 0, 255, 0);
    request(2);
    ack_coin(0, 1'b1, 1'b0, 10);
    wait_drain();

    // Reset during a nickel dispense: disp drops, idle, inventory cleared, no done
    do_reset();
    refill(1'b0, 1'b1, 3);
    push_coin(K_C5, 0);
    request(1);
    wait_disp();
    cyc(2);
    rst = 1'b1;
    push_stat(0, 0, 0, 0);
    cyc(3);
    rst = 1'b0;
    wait_drain();
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
